regfile_port_sequencer: RTL and testbench

REGFILE_PORT_SEQUENCER -- requirements
Module: regfile_port_sequencer

---
 rtl/regfile_seq_pkg.sv | 14 +
 rtl/regfile_port_sequencer.sv | 111 +++++++++++
 tb/tb_regfile_port_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file port sequencer.
package regfile_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  localparam int   ADDR_W   = 5;

endpackage

// File: rtl/regfile_port_sequencer.sv
// Sequences one read-pair or write command at a time onto an external
// register file: accept -> one access cycle -> response held until taken.
module regfile_port_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int N     = 32,
  parameter int N_REG = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [N-1:0]      cmd_wd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [N-1:0]      rsp_d1,
  output logic [N-1:0]      rsp_d2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  output logic [N-1:0]      rf_wd,
  input  logic [N-1:0]      rf_rd1,
  input  logic [N-1:0]      rf_rd2,
  output logic [15:0]       txn_count
);

  if (N_REG < 1 || N_REG > (1 << ADDR_W)) begin : g_nreg_chk
    $error("N_REG must fit the 5-bit register address");
  end

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [N-1:0]      wd_q, wd_d;
  logic [N-1:0]      d1_q, d1_d, d2_q, d2_d;
  logic [15:0]       txn_count_q, txn_count_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    wd_d        = wd_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    txn_count_d = txn_count_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          ra_d    = cmd_ra;
          rb_d    = cmd_rb;
          wd_d    = cmd_wd;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Write acks carry zero data; reads sample the combinational ports.
        d1_d    = (op_q == OP_WRITE) ? '0 : rf_rd1;
        d2_d    = (op_q == OP_WRITE) ? '0 : rf_rd2;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          txn_count_d = txn_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      ra_q        <= '0;
      rb_q        <= '0;
      wd_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      wd_q        <= wd_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      txn_count_q <= txn_count_d;
    end
  end

  // Latched command fields drive the ports directly, so they hold outside ISSUE.
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_write = (state_q == RESP) && (op_q == OP_WRITE);
  assign rf_we     = (state_q == ISSUE) && (op_q == OP_WRITE);
  assign rf_a1     = ra_q;
  assign rf_a2     = rb_q;
  assign rf_wd     = wd_q;
  assign rsp_d1    = d1_q;
  assign rsp_d2    = d2_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench: sequencer plus a behavioural register file, table vectors
// and hand sequences for back-to-back, reset-in-flight and counter wrap.
module tb_regfile_port_sequencer;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready, cmd_op;
  logic [4:0]   cmd_ra, cmd_rb;
  logic [N-1:0] cmd_wd;
  logic         rsp_valid, rsp_ready, rsp_write;
  logic [N-1:0] rsp_d1, rsp_d2;
  logic         rf_we;
  logic [4:0]   rf_a1, rf_a2;
  logic [N-1:0] rf_wd, rf_rd1, rf_rd2;
  logic [15:0]  txn_count;

  always #5 clk = ~clk;

  regfile_port_sequencer #(.N(N), .N_REG(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_wd(cmd_wd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_d1(rsp_d1), .rsp_d2(rsp_d2),
    .rf_we(rf_we), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_wd(rf_wd),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .txn_count(txn_count)
  );

  // Behavioural register file: combinational read, write on rising edge.
  logic [N-1:0] regs [32];
  logic         rf_clr;
  always_ff @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[rf_a1] <= rf_wd;
    end
  end
  assign rf_rd1 = regs[rf_a1];
  assign rf_rd2 = regs[rf_a2];

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         op;
    logic [4:0]   ra;
    logic [4:0]   rb;
    logic [N-1:0] wd;
    logic [N-1:0] e1;
    logic [N-1:0] e2;
    int           hold;
  } vec_t;

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_txn(input vec_t v);
    int n;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_ra = v.ra; cmd_rb = v.rb; cmd_wd = v.wd;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 50), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("issue_we", 64'(rf_we), 64'(v.op));
    chk("issue_a1", 64'(rf_a1), 64'(v.ra));
    if (v.op) chk("issue_wd", 64'(rf_wd), 64'(v.wd));
    else      chk("issue_a2", 64'(rf_a2), 64'(v.rb));
    chk("issue_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("issue_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("resp_we", 64'(rf_we), 64'd0);
    chk("resp_a1_hold", 64'(rf_a1), 64'(v.ra));
    chk("resp_valid", 64'(rsp_valid), 64'd1);
    chk("resp_write", 64'(rsp_write), 64'(v.op));
    chk("resp_d1", 64'(rsp_d1), 64'(v.e1));
    chk("resp_d2", 64'(rsp_d2), 64'(v.e2));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_d1", 64'(rsp_d1), 64'(v.e1));
      chk("hold_d2", 64'(rsp_d2), 64'(v.e2));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_count", 64'(txn_count), 64'(exp_cnt));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("done_count", 64'(txn_count), 64'(exp_cnt));
    chk("done_valid", 64'(rsp_valid), 64'd0);
    chk("done_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  vec_t vecs [7];
  vec_t v;
  int   acc [2];
  int   cyc;
  int   na;

  initial begin
    vecs[0] = '{1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        0};
    vecs[1] = '{1'b0, 5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        0};
    vecs[2] = '{1'b1, 5'd0,  5'd9,  32'hA5A5A5A5, 32'h0,        32'h0,        0};
    vecs[3] = '{1'b0, 5'd0,  5'd5,  32'h0,        32'hA5A5A5A5, 32'hDEADBEEF, 0};
    vecs[4] = '{1'b1, 5'd31, 5'd2,  32'h12345678, 32'h0,        32'h0,        2};
    vecs[5] = '{1'b0, 5'd31, 5'd0,  32'h0,        32'h12345678, 32'hA5A5A5A5, 0};
    vecs[6] = '{1'b0, 5'd5,  5'd31, 32'h0,        32'hDEADBEEF, 32'h12345678, 10};

    reset = 1'b1; rf_clr = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_ra = '0; cmd_rb = '0; cmd_wd = '0; rsp_ready = 1'b0; exp_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_a1", 64'(rf_a1), 64'd0);
    chk("rst_a2", 64'(rf_a2), 64'd0);
    chk("rst_wd", 64'(rf_wd), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_write", 64'(rsp_write), 64'd0);
    chk("rst_d1", 64'(rsp_d1), 64'd0);
    chk("rst_count", 64'(txn_count), 64'd0);
    reset = 1'b0; rf_clr = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Stray rsp_ready while idle must not count.
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_ready_count", 64'(txn_count), 64'(exp_cnt));

    // Back-to-back: cmd_valid stays high, consumer always ready.
    rsp_ready = 1'b1; cmd_valid = 1'b1;
    cmd_op = 1'b1; cmd_ra = 5'd31; cmd_rb = 5'd0; cmd_wd = 32'h1;
    na = 0; cyc = 0;
    while (na < 2 && cyc < 40) begin
      if (cmd_ready) begin
        acc[na] = cyc;
        na++;
        @(negedge clk);
        cyc++;
        cmd_op = 1'b0; cmd_ra = 5'd31; cmd_rb = 5'd31;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("b2b_accepts", 64'(na), 64'd2);
    chk("b2b_spacing", 64'(acc[1] - acc[0]), 64'd3);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("b2b_rsp_write", 64'(rsp_write), 64'd0);
    chk("b2b_d1", 64'(rsp_d1), 64'h1);
    chk("b2b_d2", 64'(rsp_d2), 64'h1);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd2;
    chk("b2b_count", 64'(txn_count), 64'(exp_cnt));

    // Reset in ISSUE of a write: nothing committed, no response.
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_ra = 5'd7; cmd_rb = 5'd0; cmd_wd = 32'h55;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_issue_we", 64'(rf_we), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_count", 64'(txn_count), 64'd0);
    exp_cnt = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_r7", 64'(regs[7]), 64'd0);
    chk("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);

    // Writes committed before reset survive it.
    v = '{1'b0, 5'd5, 5'd31, 32'h0, 32'hDEADBEEF, 32'h1, 0};
    run_txn(v);

    // Counter wrap from a preloaded value.
    force dut.txn_count_q = 16'hFFFE;
    #1 release dut.txn_count_q;
    exp_cnt = 16'hFFFE;
    chk("preload", 64'(txn_count), 64'hFFFE);
    v = '{1'b0, 5'd0, 5'd0, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0};
    run_txn(v);
    chk("pre_wrap", 64'(txn_count), 64'hFFFF);
    run_txn(v);
    chk("wrap", 64'(txn_count), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
